// File: rtl/data_mem_lsu.sv
// Load/store unit between the core memory stage and a word-wide synchronous
// single-port data memory. Sub-word stores are done as read-modify-write
// because the memory has no byte enables.
module data_mem_lsu #(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        req_fire;

  // Byte-address bits above the word index are deliberately ignored.
  logic        unused_addr_bits;

  assign req_fire         = req_valid & req_ready;
  assign unused_addr_bits = ^{req_addr[31:MEM_AW+2]};

  // Misaligned halfword/word, reserved funct3, or unsigned-store encodings.
  function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] lane);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return lane[0];
      3'b010:  return lane != 2'b00;
      3'b100:  return we;
      3'b101:  return we | lane[0];
      default: return 1'b1;
    endcase
  endfunction

  // Select the addressed lane and sign- or zero-extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'h000000, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte/halfword; the rest of the word is kept.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wdata);
    logic [31:0] r;
    r = word;
    if (f3 == 3'b000)
      r[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (lane[1])
      r[31:16] = wdata;
    else
      r[15:0] = wdata;
    return r;
  endfunction

  // Request sequencer; every output is a register set on the transition
  // into the state that owns it, so strobes follow the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            rsp_rdata <= '0;
            if (req_illegal(req_we, req_funct3, req_addr[1:0])) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (req_we && req_funct3 == 3'b010) begin
              mem_addr  <= req_addr[MEM_AW+1:2];
              mem_wdata <= req_wdata;
              mem_we    <= 1'b1;
              state     <= WRITE;
            end else begin
              mem_addr  <= req_addr[MEM_AW+1:2];
              mem_re    <= 1'b1;
              state     <= READ;
            end
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          if (we_q) begin
            mem_wdata <= store_merge(mem_rdata, f3_q, lane_q, wdata_q);
            mem_we    <= 1'b1;
            state     <= WRITE;
          end else begin
            rsp_rdata <= load_extract(mem_rdata, f3_q, lane_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        WRITE: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
